// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the 8-bit PWM block and its waveform
//               source: duty-value width and wave_sel encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Width of the duty value consumed by the PWM (one 8-bit period = 256 clk).
  localparam int DUTY_W = 8;

  // wave_sel encodings
  localparam logic [1:0] WAVE_RAMP_UP = 2'd0;
  localparam logic [1:0] WAVE_RAMP_DN = 2'd1;
  localparam logic [1:0] WAVE_TRI     = 2'd2;
  localparam logic [1:0] WAVE_SQR     = 2'd3;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/wave_shaper.sv
`default_nettype none
// ============================================================================
// Module      : wave_shaper
// Description : Purely combinational waveform function f(p, wave_sel).
//               Maps the top byte of the phase accumulator onto a duty value.
// Ports       : p        - phase sample (top DUTY_W bits of the accumulator)
//               wave_sel - 0 ramp-up, 1 ramp-down, 2 triangle, 3 square
//               y        - shaped duty value
// Revision    : 1.0 - initial release
// ============================================================================
module wave_shaper
  import pwm_pkg::*;
(
  input  logic [DUTY_W-1:0] p,
  input  logic [1:0]        wave_sel,
  output logic [DUTY_W-1:0] y
);

  // Triangle: the lower half of the phase is doubled for the rising edge, the
  // upper half reuses the same doubled slope inverted for the falling edge.
  logic [DUTY_W-1:0] w_tri_slope;
  assign w_tri_slope = {p[DUTY_W-2:0], 1'b0};

  always_comb begin
    y = p;
    case (wave_sel)
      WAVE_RAMP_UP: y = p;
      WAVE_RAMP_DN: y = ~p;
      WAVE_TRI:     y = p[DUTY_W-1] ? ~w_tri_slope : w_tri_slope;
      WAVE_SQR:     y = p[DUTY_W-1] ? {DUTY_W{1'b0}} : {DUTY_W{1'b1}};
      default:      y = p;
    endcase
  end

endmodule : wave_shaper
`default_nettype wire

// File: rtl/pwm_wave_source.sv
`default_nettype none
// ============================================================================
// Module      : pwm_wave_source
// Description : Upstream waveform generator for the 8-bit PWM. A phase
//               accumulator advances once per PWM frame (2^FRAME_W clocks) and
//               the shaped sample is registered onto `data` at the same time,
//               so the PWM sees a stable duty value for a whole period.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous active-high reset
//               en          - 1: phase advances at frame boundary, 0: holds
//               wave_sel    - 0 ramp-up, 1 ramp-down, 2 triangle, 3 square
//               freq_sel    - phase increment per frame (unsigned)
//               data        - registered duty value to the PWM
//               frame_start - one-clock pulse in first cycle of each frame
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_wave_source
  import pwm_pkg::*;
#(
  parameter int FRAME_W = 8,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] freq_sel,
  output logic [DUTY_W-1:0]  data,
  output logic               frame_start
);

  logic [FRAME_W-1:0] r_frame_cnt;
  logic [PHASE_W-1:0] r_phase;

  logic               w_boundary;
  logic [PHASE_W-1:0] w_phase_next;
  logic [DUTY_W-1:0]  w_sample;
  logic [DUTY_W-1:0]  w_shaped;

  // Last cycle of a frame; all inputs are only looked at here.
  assign w_boundary = &r_frame_cnt;

  // Carry out of the accumulator is dropped: wrap-around is silent.
  assign w_phase_next = en ? (r_phase + freq_sel) : r_phase;

  // The shaped value uses the phase that is being committed this edge, so
  // `data` and `phase` always stay consistent with each other.
  assign w_sample = w_phase_next[PHASE_W-1 -: DUTY_W];

  wave_shaper u_wave_shaper (
    .p        (w_sample),
    .wave_sel (wave_sel),
    .y        (w_shaped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_phase     <= '0;
      data        <= '0;
      frame_start <= 1'b0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
      frame_start <= w_boundary;
      if (w_boundary) begin
        r_phase <= w_phase_next;
        data    <= w_shaped;
      end
    end
  end

endmodule : pwm_wave_source
`default_nettype wire

// File: tb/tb_pwm_wave_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_wave_source
// Description : Self-checking bench for pwm_wave_source. Expected duty values
//               are pushed to a scoreboard queue when a frame's inputs are
//               driven and popped when the DUT raises frame_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_wave_source;

  localparam int FRAME_W  = 8;
  localparam int PHASE_W  = 16;
  localparam int FRAME_LEN = 1 << FRAME_W;

  logic               clk;
  logic               rst;
  logic               en;
  logic [1:0]         wave_sel;
  logic [PHASE_W-1:0] freq_sel;
  logic [7:0]         data;
  logic               frame_start;

  int total = 0;
  int bad   = 0;

  logic [7:0]         exp_q[$];
  logic [PHASE_W-1:0] m_phase;

  pwm_wave_source #(.FRAME_W(FRAME_W), .PHASE_W(PHASE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wave_sel    (wave_sel),
    .freq_sel    (freq_sel),
    .data        (data),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference waveform, written arithmetically rather than bitwise.
  function automatic logic [7:0] shape(input logic [7:0] p, input logic [1:0] w);
    int pi;
    pi = int'(p);
    case (w)
      2'd0:    return p;
      2'd1:    return 8'(255 - pi);
      2'd2:    return (pi < 128) ? 8'(pi * 2) : 8'(255 - (pi - 128) * 2);
      default: return (pi < 128) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Monitor: frame spacing, data stability inside a frame, scoreboard pop.
  int         cyc = 0;
  logic       unstable = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      cyc      = 0;
      unstable = 1'b0;
    end else begin
      cyc++;
      if (frame_start) begin
        chk("frame_len", cyc, FRAME_LEN);
        chk("stable_in_frame", {31'd0, unstable}, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          chk("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        cyc      = 0;
        unstable = 1'b0;
      end else if (data !== prev_data) begin
        unstable = 1'b1;
      end
    end
    prev_data = data;
  end

  // Reset asserted mid-frame, held for n cycles; outputs must stay cleared.
  task automatic do_reset(input int n);
    @(negedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_data", {24'd0, data}, 0);
      chk("rst_fs", {31'd0, frame_start}, 0);
    end
    #1;
    rst     = 1'b0;
    m_phase = '0;
  endtask

  // Wait (bounded) for the frame_start that ends the current frame.
  task automatic wait_frame();
    int k;
    k = 0;
    while (k < FRAME_LEN + 8) begin
      @(negedge clk);
      if (frame_start) break;
      k++;
    end
    if (k >= FRAME_LEN + 8) chk("frame_timeout", 0, 1);
  endtask

  // Drive one frame's inputs after `pre` cycles, record the expectation,
  // then wait for the frame to end.
  task automatic frame(input logic [1:0] w, input logic [PHASE_W-1:0] f,
                       input logic e, input int pre);
    for (int i = 0; i < pre; i++) @(negedge clk);
    #1;
    wave_sel = w;
    freq_sel = f;
    en       = e;
    if (e) m_phase = m_phase + f;
    exp_q.push_back(shape(m_phase[PHASE_W-1 -: 8], w));
    wait_frame();
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    wave_sel = 2'd0;
    freq_sel = 16'h0100;
    m_phase  = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    // Run part way into a frame, then reset mid-frame.
    repeat (100) @(negedge clk);
    do_reset(10);

    // Ramp-up: 01, 02, ..., FF, 00, 01 ... across the wrap.
    for (int i = 0; i < 258; i++) frame(2'd0, 16'h0100, 1'b1, 0);

    do_reset(10);
    // Square: FF, 00, 00, FF repeating.
    for (int i = 0; i < 8; i++) frame(2'd3, 16'h4000, 1'b1, 0);

    do_reset(10);
    // Triangle: 40, 80, C0, FF, BF, 7F, 3F, 00 repeating.
    for (int i = 0; i < 16; i++) frame(2'd2, 16'h2000, 1'b1, 0);

    // Inputs changed mid-frame only take effect at the next boundary.
    frame(2'd1, 16'h1234, 1'b1, 100);
    frame(2'd0, 16'h0777, 1'b1, 100);
    // Phase frozen; data still refreshed with the current wave_sel.
    frame(2'd0, 16'h5555, 1'b0, 100);
    frame(2'd0, 16'h5555, 1'b0, 50);
    frame(2'd1, 16'h5555, 1'b0, 20);
    frame(2'd3, 16'h0000, 1'b1, 0);
    // Zero increment: constant output.
    frame(2'd2, 16'h0000, 1'b1, 0);
    frame(2'd2, 16'h0000, 1'b1, 0);
    // Large increment exercising silent phase wrap.
    frame(2'd0, 16'hF000, 1'b1, 0);
    frame(2'd0, 16'hF000, 1'b1, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_wave_source
`default_nettype wire

// File: doc/pwm_wave_source.md
Name: pwm_wave_source

Overview:
- Upstream stage of the 8-bit PWM block. Generates the `data` duty value that the PWM consumes.
- Synthesises a periodic waveform (ramp-up, ramp-down, triangle, square) using a phase accumulator.
- Updates the duty value exactly once per PWM frame (2^FRAME_W clocks), so the PWM sees a stable `data` for a whole period.
- `frame_start` marks each frame boundary so the downstream PWM/test bench can align.

Parameters:
- FRAME_W, 8: frame-counter width; frame length = 2^FRAME_W clocks (matches the 8-bit PWM period of 256).
- PHASE_W, 16: phase-accumulator width; output sample uses phase[PHASE_W-1 -: 8].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  1 = phase advances at each frame boundary; 0 = phase holds (frame counter still runs).
- wave_sel  input  2  0 = ramp-up, 1 = ramp-down, 2 = triangle, 3 = square.
- freq_sel  input  PHASE_W  phase increment per frame (unsigned).
- data  output  8  duty value to PWM; registered.
- frame_start  output  1  one-clock pulse, high in the first cycle of each frame (same cycle `data` changes).

Behaviour:
- Clocking and reset:
  - Single clock domain; clk is the only clock.
  - rst is synchronous and active-high.
  - While rst = 1 at a rising edge: frame_cnt <= 0, phase <= 0, data <= 8'h00, frame_start <= 0.
  - Reset mid-frame aborts the frame; no partial update is kept.
- Frame counter: frame_cnt (FRAME_W bits) increments every clock and wraps 2^FRAME_W-1 -> 0.
- Boundary cycle (frame_cnt == all-ones, registered actions at that edge):
  - phase_next = en ? phase + freq_sel : phase (mod 2^PHASE_W, carry discarded).
  - phase <= phase_next.
  - data <= f(p, wave_sel), with p = phase_next[PHASE_W-1 -: 8].
  - frame_start <= 1.
- All other cycles: frame_start <= 0; phase and data hold.
- Sampling: wave_sel, freq_sel and en are sampled only in the boundary cycle. Changes at any other time have no effect until the next boundary.
- Latency: an input change visible at boundary cycle N appears on `data` at cycle N+1, coincident with frame_start = 1.
- After reset release: first frame_start occurs 2^FRAME_W clocks after the first non-reset edge (cycle index 256 for the default).
- Waveform function f(p, wave_sel):
  - ramp-up: p.
  - ramp-down: ~p.
  - triangle: p[7] = 0 -> {p[6:0],1'b0}; p[7] = 1 -> ~{p[6:0],1'b0}.
  - square: p[7] = 0 -> 8'hFF; p[7] = 1 -> 8'h00.
- Boundary conditions:
  - freq_sel = 0 -> data constant at f(current phase).
  - Phase wrap-around is silent (no flag).
  - en toggled low still refreshes `data` with the current wave_sel at the boundary; only phase is frozen.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package pwm_pkg:
  - wave_sel encodings WAVE_RAMP_UP = 2'd0, WAVE_RAMP_DN = 2'd1, WAVE_TRI = 2'd2, WAVE_SQR = 2'd3.
  - DUTY_W = 8.
- One natural sub-module: wave_shaper, a combinational f(p, wave_sel) -> 8-bit.
- Frame counter, accumulator and output register stay in the top.

Test Plan:
- Reset: hold rst 10 cycles mid-frame with en = 1, freq_sel = 16'h0100 -> data = 00 and frame_start = 0 throughout. After release, first frame_start at cycle 256 with data = 01.
- Ramp-up: wave_sel = 0, freq_sel = 16'h0100, en = 1 for 300 frames -> data 01, 02, ..., FF, 00, 01, ... (wraps at frame 256). Each value stable for exactly 256 clocks.
- Square: wave_sel = 3, freq_sel = 16'h4000 -> p = 40, 80, C0, 00 -> data FF, 00, 00, FF, repeating.
- Triangle: wave_sel = 2, freq_sel = 16'h2000 -> data 40, 80, C0, FF, BF, 7F, 3F, 00, repeating.
- Input timing: change freq_sel and wave_sel at frame_cnt = 100 -> no data change until the next frame_start. With en = 0, phase holds and data repeats its value. Also drive the PWM block with this output and check its duty equals data/256 each frame.
